// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use/branch hazard stalls, branch flush, multiply hold, perf counters
//
// Purpose: sequencing control for the 5-stage pipeline. Stalls PC and IF/ID and
// bubbles ID/EX on hazards the forwarding unit cannot cover, squashes IF/ID on
// taken branches and jumps, and freezes the front end while a multi-cycle
// multiply occupies EX. Counts stall cycles and flushes (saturating).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ID_Rs, ID_Rt, ID_UsesRt    source operands of the instruction in ID
//   ID_Branch, ID_BranchTaken  conditional branch in ID and its ID-stage compare result
//   ID_Jump, ID_IsMul          unconditional jump / multiply in ID
//   EX_Dst, EX_RegWrite, EX_MemRead   destination info of the instruction in ID/EX
//   MEM_Dst, MEM_MemRead       destination info of the instruction in EX/MEM
//   PC_Write, IFID_Write, IDEX_Write  register enables
//   IFID_Flush, IDEX_Bubble, EXMEM_Bubble  squash / NOP-injection controls
//   Stall_Cycles, Flush_Count  saturating performance counters
module hazard_stall_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_IsMul,
  input  logic [4:0]       EX_Dst,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_Dst,
  input  logic             MEM_MemRead,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic {RUN, MUL_BUSY} state_e;

  // The cycle that launches the multiply counts as its first EX cycle, so the
  // hold covers the remaining MUL_LATENCY-1 cycles.
  localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_match, mem_match;
  logic load_use, branch_alu, branch_load, stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  always_comb begin
    ex_match  = (EX_Dst != 5'd0) &&
                ((EX_Dst == ID_Rs) || (ID_UsesRt && (EX_Dst == ID_Rt)));
    mem_match = (MEM_Dst != 5'd0) &&
                ((MEM_Dst == ID_Rs) || (ID_UsesRt && (MEM_Dst == ID_Rt)));
    load_use    = EX_MemRead && ex_match;
    // ALU results in EX are forwardable to EX but not to the ID-stage compare.
    branch_alu  = ID_Branch && EX_RegWrite && !EX_MemRead && ex_match;
    branch_load = ID_Branch && MEM_MemRead && mem_match;
    stall       = load_use || branch_alu || branch_load;
  end

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (stall) begin
          // Hold the dependent instruction in ID; its branch/jump/mul waits.
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
        end else begin
          IFID_Flush = (ID_Branch && ID_BranchTaken) || ID_Jump;
          if (ID_IsMul && (MUL_LATENCY > 1)) begin
            state_d   = MUL_BUSY;
            mul_cnt_d = MUL_INIT;
          end
        end
      end
      MUL_BUSY: begin
        // Multiply keeps ID/EX; everything ahead of it is frozen.
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        mul_cnt_d    = mul_cnt_q - 4'd1;
        if (mul_cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        mul_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_Write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (IFID_Flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mul_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cycles = stall_cnt_q;
  assign Flush_Count  = flush_cnt_q;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage CPU. It works alongside the forwarding unit and covers the hazards that forwarding cannot resolve.
- Detects load-use and ID-stage branch-operand hazards, then stalls PC and IF/ID and injects ID/EX bubbles.
- Squashes IF/ID on taken branches and jumps.
- Freezes the front of the pipeline while a multi-cycle multiply occupies EX, and keeps stall and flush performance counters.

Parameters:
- MUL_LATENCY, 4, cycles a multiply occupies EX (legal range 1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  source register of the instruction in ID.
- ID_Rt  in  5  second source register of the instruction in ID.
- ID_UsesRt  in  1  instruction in ID reads Rt.
- ID_Branch  in  1  instruction in ID is a conditional branch; its compare is done in ID.
- ID_BranchTaken  in  1  ID compare result; meaningful only when ID_Branch=1.
- ID_Jump  in  1  instruction in ID is an unconditional jump.
- ID_IsMul  in  1  instruction in ID is a multiply.
- EX_Dst  in  5  destination register in ID/EX.
- EX_RegWrite  in  1  instruction in ID/EX writes a register.
- EX_MemRead  in  1  instruction in ID/EX is a load.
- MEM_Dst  in  5  destination register in EX/MEM.
- MEM_MemRead  in  1  instruction in EX/MEM is a load.
- PC_Write  out  1  PC load enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  zero IF/ID at the next edge.
- IDEX_Write  out  1  ID/EX register enable.
- IDEX_Bubble  out  1  load a NOP into ID/EX at the next edge.
- EXMEM_Bubble  out  1  load a NOP into EX/MEM at the next edge.
- Stall_Cycles  out  CNT_W  saturating count of cycles with PC_Write=0.
- Flush_Count  out  CNT_W  saturating count of cycles with IFID_Flush=1.

Behaviour:
- State: a 2-state FSM (RUN, MUL_BUSY) plus a 4-bit mul_cnt, both registered. All control outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous): state=RUN, mul_cnt=0, both counters=0. With quiescent inputs the outputs are PC_Write=1, IFID_Write=1, IDEX_Write=1, and all flush/bubble outputs 0.
- Register match rule: r matches when r!=0 and r==ID_Rs, or when r!=0, ID_UsesRt=1 and r==ID_Rt. Register 0 never causes a hazard.
- Stall condition (evaluated in RUN only), asserted if any of:
  - load-use: EX_MemRead and EX_Dst matches.
  - branch-ALU: ID_Branch, EX_RegWrite, !EX_MemRead, and EX_Dst matches.
  - branch-load: ID_Branch, MEM_MemRead, and MEM_Dst matches.
  - A branch depending on a load in EX therefore stalls 2 cycles: load-use fires first, then branch-load.
- RUN with stall: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0. A branch or jump in ID is ignored until the stall clears.
- RUN without stall:
  - All enables are 1.
  - IFID_Flush = (ID_Branch & ID_BranchTaken) | ID_Jump.
  - If ID_IsMul=1 and MUL_LATENCY>1: at the edge, go to MUL_BUSY and load mul_cnt=MUL_LATENCY-1.
- MUL_BUSY:
  - PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1, IDEX_Bubble=0, IFID_Flush=0.
  - Hazard inputs are ignored.
  - mul_cnt decrements each edge; when it reaches 0, the next state is RUN.
  - The mul is in EX for exactly MUL_LATENCY cycles. On the final cycle the state is RUN, so the result enters EX/MEM.
- Priority: MUL_BUSY hold > data stall > flush.
- A mul held in ID by a data stall does not start until the stall clears.
- Counters:
  - Stall_Cycles increments on each edge where PC_Write=0.
  - Flush_Count increments on each edge where IFID_Flush=1.
  - Both saturate at all-ones with no wrap.
- Reset mid-operation: asserting rst_n during MUL_BUSY immediately returns state to RUN with mul_cnt=0. Releasing the pipeline is the datapath reset's responsibility.
- MUL_LATENCY=1: never enters MUL_BUSY.

Test Plan:
1. Load-use: EX_MemRead=1, EX_Dst=5, ID_Rs=5 for 1 cycle → PC_Write=0, IFID_Write=0, IDEX_Bubble=1; Stall_Cycles 0→1. Repeat with EX_Dst=0 → no stall.
2. Branch after load: ID_Branch=1, ID_Rt=8, ID_UsesRt=1. Cycle 1: EX load to r8; cycle 2: MEM load to r8 → 2 stall cycles, IFID_Flush=0 both. Cycle 3 with ID_BranchTaken=1 → IFID_Flush=1, Flush_Count=1.
3. Branch after ALU: ID_Branch=1, EX_RegWrite=1, EX_MemRead=0, EX_Dst=ID_Rs=3 → exactly 1 stall cycle; ID_UsesRt=0 with EX_Dst=ID_Rt does not stall.
4. Multiply, MUL_LATENCY=4: ID_IsMul=1 in RUN → next 3 cycles IDEX_Write=0, EXMEM_Bubble=1, PC_Write=0; cycle 4 back in RUN, all enables 1; Stall_Cycles=3. Same in an instance with MUL_LATENCY=1 → zero hold cycles.
5. Priority: in MUL_BUSY, drive load-use match and ID_Jump=1 → no IDEX_Bubble, no IFID_Flush. Assert rst_n=0 mid-mul → outputs immediately at reset values, counters 0.
6. Saturation: instance with CNT_W=4; hold load-use stall 20 cycles → Stall_Cycles stays at 15.
